// File: rtl/vrf_writeback_arbiter.sv
// Per-lane VRF write-port arbiter: exec writes win, colliding loads queue in a small FIFO and drain on idle cycles.
// Optional perf counters (conflict_count, max_occupancy) are built only when VRF_WB_PERF_EN is defined.
module vrf_writeback_arbiter #(
  parameter int LANES_DATA_WIDTH    = 64,
  parameter int NUMBER_VECTOR_LANES = 4,
  parameter int LOAD_FIFO_DEPTH     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUMBER_VECTOR_LANES-1:0][4:0]                   destination_in,
  input  logic [NUMBER_VECTOR_LANES-1:0][LANES_DATA_WIDTH-1:0]  data_write_in,
  input  logic [NUMBER_VECTOR_LANES-1:0]                        write_enable_in,
  input  logic [NUMBER_VECTOR_LANES-1:0][4:0]                   load_destination_in,
  input  logic [NUMBER_VECTOR_LANES-1:0][LANES_DATA_WIDTH-1:0]  data_from_load_in,
  input  logic [NUMBER_VECTOR_LANES-1:0]                        read_done_in,
  output logic [NUMBER_VECTOR_LANES-1:0]                        vrf_write_enable,
  output logic [NUMBER_VECTOR_LANES-1:0][4:0]                   vrf_destination,
  output logic [NUMBER_VECTOR_LANES-1:0][LANES_DATA_WIDTH-1:0]  vrf_data,
  output logic [NUMBER_VECTOR_LANES-1:0]                        load_stall,
  output logic [NUMBER_VECTOR_LANES-1:0]                        load_overflow,
  output logic                                                  wb_idle
`ifdef VRF_WB_PERF_EN
  ,
  output logic [31:0]                                           conflict_count,
  output logic [$clog2(LOAD_FIFO_DEPTH):0]                      max_occupancy
`endif
);

  localparam int PW = $clog2(LOAD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(LOAD_FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(LOAD_FIFO_DEPTH - 1);

  logic [CW-1:0]                  lane_count [NUMBER_VECTOR_LANES];
  logic [NUMBER_VECTOR_LANES-1:0] lane_busy;
  logic [NUMBER_VECTOR_LANES-1:0] lane_conflict;

  for (genvar i = 0; i < NUMBER_VECTOR_LANES; i++) begin : g_lane
    logic [4:0]                  mem_dest [LOAD_FIFO_DEPTH];
    logic [LANES_DATA_WIDTH-1:0] mem_data [LOAD_FIFO_DEPTH];
    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic [CW-1:0]               count;
    logic                        sel_exec, sel_drain, sel_bypass;
    logic                        full, push, push_ok;
    logic                        we_q, ovf_q;
    logic [4:0]                  dest_q;
    logic [LANES_DATA_WIDTH-1:0] data_q;

    always_comb begin
      sel_exec   = write_enable_in[i];
      sel_drain  = !write_enable_in[i] && (count != '0);
      sel_bypass = !write_enable_in[i] && (count == '0) && read_done_in[i];
      full       = (count == FULL_CNT);
      push       = read_done_in[i] && !sel_bypass;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push_ok    = push && (!full || sel_drain);
    end

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem_dest[wr_ptr] <= load_destination_in[i];
        mem_data[wr_ptr] <= data_from_load_in[i];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        we_q   <= 1'b0;
        dest_q <= '0;
        data_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + PW'(1);
        if (sel_drain)
          rd_ptr <= rd_ptr + PW'(1);
        case ({push_ok, sel_drain})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (push && !push_ok)
          ovf_q <= 1'b1;
        we_q <= sel_exec || sel_drain || sel_bypass;
        if (sel_exec) begin
          dest_q <= destination_in[i];
          data_q <= data_write_in[i];
        end else if (sel_drain) begin
          dest_q <= mem_dest[rd_ptr];
          data_q <= mem_data[rd_ptr];
        end else if (sel_bypass) begin
          dest_q <= load_destination_in[i];
          data_q <= data_from_load_in[i];
        end
      end
    end

    assign vrf_write_enable[i] = we_q;
    assign vrf_destination[i]  = dest_q;
    assign vrf_data[i]         = data_q;
    assign load_overflow[i]    = ovf_q;
    assign load_stall[i]       = (count >= STALL_CNT);
    assign lane_count[i]       = count;
    assign lane_busy[i]        = (count != '0);
    assign lane_conflict[i]    = push_ok && sel_exec;
  end

  assign wb_idle = !(|lane_busy) && !(|vrf_write_enable);

`ifdef VRF_WB_PERF_EN
  logic [CW-1:0] cur_max;

  always_comb begin
    cur_max = '0;
    for (int k = 0; k < NUMBER_VECTOR_LANES; k++)
      if (lane_count[k] > cur_max)
        cur_max = lane_count[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count <= '0;
      max_occupancy  <= '0;
    end else begin
      if ((|lane_conflict) && (conflict_count != 32'hFFFF_FFFF))
        conflict_count <= conflict_count + 32'd1;
      if (cur_max > max_occupancy)
        max_occupancy <= cur_max;
    end
  end
`else
  logic unused_conflict;
  assign unused_conflict = |lane_conflict;
`endif

endmodule

// File: tb/tb_vrf_writeback_arbiter.sv
// Scoreboard bench: a queue-based lane model predicts VRF writes, a negedge monitor checks them.
module tb_vrf_writeback_arbiter;
  localparam int W = 64;
  localparam int L = 4;
  localparam int D = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [L-1:0][4:0]     destination_in;
  logic [L-1:0][W-1:0]   data_write_in;
  logic [L-1:0]          write_enable_in;
  logic [L-1:0][4:0]     load_destination_in;
  logic [L-1:0][W-1:0]   data_from_load_in;
  logic [L-1:0]          read_done_in;
  logic [L-1:0]          vrf_write_enable;
  logic [L-1:0][4:0]     vrf_destination;
  logic [L-1:0][W-1:0]   vrf_data;
  logic [L-1:0]          load_stall;
  logic [L-1:0]          load_overflow;
  logic                  wb_idle;

  vrf_writeback_arbiter #(.LANES_DATA_WIDTH(W), .NUMBER_VECTOR_LANES(L), .LOAD_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .destination_in(destination_in), .data_write_in(data_write_in), .write_enable_in(write_enable_in),
    .load_destination_in(load_destination_in), .data_from_load_in(data_from_load_in), .read_done_in(read_done_in),
    .vrf_write_enable(vrf_write_enable), .vrf_destination(vrf_destination), .vrf_data(vrf_data),
    .load_stall(load_stall), .load_overflow(load_overflow), .wb_idle(wb_idle));

  always #5 clk = ~clk;

  typedef struct { int due; logic [4:0] dest; logic [W-1:0] data; } exp_t;
  typedef struct { logic [4:0] dest; logic [W-1:0] data; } ld_t;

  exp_t       exp_q [L][$];
  ld_t        mfifo [L][$];
  logic       m_ovf [L];
  logic       m_wrote [L];
  logic [4:0] m_last_dest [L];
  logic [W-1:0] m_last_data [L];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic void expect_write(int l, logic [4:0] dst, logic [W-1:0] dat);
    exp_t e;
    e.due = cyc; e.dest = dst; e.data = dat;
    exp_q[l].push_back(e);
    m_wrote[l] = 1'b1;
    m_last_dest[l] = dst;
    m_last_data[l] = dat;
  endfunction

  // Reference behaviour applied to the inputs sampled at the current edge.
  function automatic void model_step();
    ld_t ld, hd;
    for (int l = 0; l < L; l++) begin
      m_wrote[l] = 1'b0;
      if (rst) begin
        mfifo[l].delete();
        exp_q[l].delete();
        m_ovf[l] = 1'b0;
        m_last_dest[l] = '0;
        m_last_data[l] = '0;
        continue;
      end
      ld.dest = load_destination_in[l];
      ld.data = data_from_load_in[l];
      if (write_enable_in[l]) begin
        expect_write(l, destination_in[l], data_write_in[l]);
        if (read_done_in[l]) begin
          if (mfifo[l].size() < D) mfifo[l].push_back(ld);
          else m_ovf[l] = 1'b1;
        end
      end else if (mfifo[l].size() > 0) begin
        hd = mfifo[l].pop_front();
        expect_write(l, hd.dest, hd.data);
        if (read_done_in[l]) mfifo[l].push_back(ld);
      end else if (read_done_in[l]) begin
        expect_write(l, ld.dest, ld.data);
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic any_busy;
    if (cyc > 0) begin
      any_busy = 1'b0;
      for (int l = 0; l < L; l++) begin
        if (vrf_write_enable[l]) begin
          if (exp_q[l].size() == 0) begin
            chk($sformatf("unexpected_write_l%0d", l), 64'(vrf_destination[l]), 64'hFFFF);
          end else begin
            e = exp_q[l].pop_front();
            chk($sformatf("latency_l%0d", l), 64'(cyc), 64'(e.due));
            chk($sformatf("dest_l%0d", l), 64'(vrf_destination[l]), 64'(e.dest));
            chk($sformatf("data_l%0d", l), vrf_data[l], e.data);
          end
        end else begin
          if (exp_q[l].size() > 0 && exp_q[l][0].due <= cyc) begin
            e = exp_q[l].pop_front();
            chk($sformatf("missing_write_l%0d", l), 64'(vrf_write_enable[l]), 64'd1);
          end
          chk($sformatf("hold_dest_l%0d", l), 64'(vrf_destination[l]), 64'(m_last_dest[l]));
          chk($sformatf("hold_data_l%0d", l), vrf_data[l], m_last_data[l]);
        end
        chk($sformatf("load_stall_l%0d", l), 64'(load_stall[l]), 64'(mfifo[l].size() >= D - 1));
        chk($sformatf("load_overflow_l%0d", l), 64'(load_overflow[l]), 64'(m_ovf[l]));
        if (mfifo[l].size() != 0 || m_wrote[l]) any_busy = 1'b1;
      end
      chk("wb_idle", 64'(wb_idle), 64'(!any_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rst = 1'b0;
    write_enable_in = '0;
    read_done_in = '0;
    destination_in = '0;
    data_write_in = '0;
    load_destination_in = '0;
    data_from_load_in = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic exec_load(input int l, input int n, input logic do_exec);
    for (int k = 0; k < n; k++) begin
      clear_in();
      write_enable_in[l] = do_exec;
      destination_in[l] = 5'(k + 10);
      data_write_in[l] = 64'h1000 + 64'(k);
      read_done_in[l] = 1'b1;
      load_destination_in[l] = 5'(k + 20);
      data_from_load_in[l] = 64'h2000 + 64'(k);
      tick();
    end
  endtask

  initial begin
    for (int l = 0; l < L; l++) begin
      m_ovf[l] = 1'b0; m_wrote[l] = 1'b0; m_last_dest[l] = '0; m_last_data[l] = '0;
    end
    clear_in();
    rst = 1'b1;
    tick(); tick();
    chk("reset_we", 64'(vrf_write_enable), 64'd0);
    chk("reset_idle", 64'(wb_idle), 64'd1);
    idle(1);

    // Bypass on lane0.
    clear_in();
    read_done_in[0] = 1'b1; load_destination_in[0] = 5'd3; data_from_load_in[0] = 64'hA5A5;
    tick();
    idle(2);

    // Collision on lane1.
    clear_in();
    write_enable_in[1] = 1'b1; destination_in[1] = 5'd7; data_write_in[1] = 64'h11;
    read_done_in[1] = 1'b1; load_destination_in[1] = 5'd9; data_from_load_in[1] = 64'h22;
    tick();
    idle(3);

    exec_load(2, 3, 1'b1);
    idle(5);
    exec_load(3, 5, 1'b1);
    idle(7);

    // Fill lane0 then push while full with no exec.
    exec_load(0, 4, 1'b1);
    exec_load(0, 1, 1'b0);
    idle(7);

    // Reset while lane0 has two queued loads.
    exec_load(0, 2, 1'b1);
    clear_in();
    rst = 1'b1;
    tick();
    idle(4);

    for (int k = 0; k < 3000; k++) begin
      int exec_pct;
      exec_pct = ((k / 100) % 2 == 0) ? 70 : 20;
      clear_in();
      rst = ($urandom_range(0, 499) == 0);
      for (int l = 0; l < L; l++) begin
        write_enable_in[l] = ($urandom_range(0, 99) < exec_pct);
        read_done_in[l] = ($urandom_range(0, 99) < 50);
        destination_in[l] = 5'($urandom);
        load_destination_in[l] = 5'($urandom);
        data_write_in[l] = {$urandom, $urandom};
        data_from_load_in[l] = {$urandom, $urandom};
      end
      tick();
    end

    idle(12);
    for (int l = 0; l < L; l++)
      chk($sformatf("drained_l%0d", l), 64'(exp_q[l].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vrf_writeback_arbiter.md
Name: vrf_writeback_arbiter

Overview:
- Per-lane write-port arbiter between the multiplexer-to-register stage and the vector register file (VRF). Each lane has one VRF write port.
- Two writeback sources per lane: execution writeback (already mask-merged) and load writeback.
- Execution always wins the port. Colliding load data is queued in a small per-lane FIFO and drained on idle cycles.
- Registered outputs give one cycle of latency into the VRF.

Parameters:
- LANES_DATA_WIDTH, 64, data width of each lane's element slice.
- NUMBER_VECTOR_LANES, 4, number of independent lanes.
- LOAD_FIFO_DEPTH, 4, load entries buffered per lane; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- destination_in  in  5 x LANES  execution destination register per lane.
- data_write_in  in  LANES_DATA_WIDTH x LANES  execution write data per lane.
- write_enable_in  in  LANES  execution write request per lane.
- load_destination_in  in  5 x LANES  load destination register per lane.
- data_from_load_in  in  LANES_DATA_WIDTH x LANES  load data per lane.
- read_done_in  in  LANES  load write request (valid) per lane.
- vrf_write_enable  out  LANES  VRF write strobe per lane.
- vrf_destination  out  5 x LANES  VRF write address per lane.
- vrf_data  out  LANES_DATA_WIDTH x LANES  VRF write data per lane.
- load_stall  out  LANES  lane FIFO almost full; upstream must hold loads.
- load_overflow  out  LANES  sticky error flag: a load was dropped.
- wb_idle  out  1  all FIFOs empty and no write issued this cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - vrf_write_enable, vrf_destination, vrf_data, load_overflow are all 0.
  - FIFO pointers and counts are 0, so load_stall=0 and wb_idle=1.
  - Reset mid-operation discards all queued loads without writing them.
- Lanes are fully independent; all rules below apply per lane i.
- Each clock, the lane selects one source for the next-cycle VRF write:
  - EXEC: write_enable_in[i]=1. Register destination_in[i]/data_write_in[i]; vrf_write_enable[i]=1 next cycle. If read_done_in[i]=1 in the same cycle, push the load into the FIFO.
  - DRAIN: write_enable_in[i]=0 and FIFO count>0. Pop the FIFO head to the outputs. A simultaneous read_done_in[i] pushes to the tail, so FIFO order is preserved.
  - BYPASS: write_enable_in[i]=0, FIFO empty, read_done_in[i]=1. Register the load directly; latency 1, no FIFO entry.
  - IDLE: none of the above. vrf_write_enable[i]=0 next cycle; vrf_destination/vrf_data hold their previous values.
- Latency:
  - EXEC and BYPASS: input to vrf_* is exactly 1 cycle.
  - Queued loads: 1 cycle after the first non-exec cycle in which they reach the FIFO head.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo LOAD_FIFO_DEPTH; count held in $clog2(LOAD_FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged, including when full.
  - Push when full with no pop: data dropped, count unchanged, load_overflow[i] set. It stays set until rst.
- load_stall[i] = (count ≥ LOAD_FIFO_DEPTH-1), decoded from registered count only (no combinational path from inputs). This gives upstream one cycle of slack.
- wb_idle = all counts 0 AND no vrf_write_enable bit set.
- Ordering between an exec write and an older queued load to the same register is guaranteed by the upstream scoreboard. The block does no address comparison.
- Input widths pass through unmodified; no sign or zero extension.

Optional Feature:
- Macro VRF_WB_PERF_EN.
- Defined:
  - Adds output conflict_count [31:0]: per-block count of cycles in which any lane pushed a load into its FIFO because of an exec collision. Saturates at 0xFFFFFFFF.
  - Adds output max_occupancy [$clog2(LOAD_FIFO_DEPTH):0]: high-water mark of FIFO count over all lanes.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Bypass: lane0 read_done_in=1, dest 5'd3, data 64'hA5A5; no exec → next cycle vrf_write_enable[0]=1, vrf_destination[0]=3, vrf_data[0]=64'hA5A5; count stays 0.
- Collision: lane1 exec (dest 7, data 64'h11) and load (dest 9, data 64'h22) in cycle 0, idle cycle 1 → cycle 1 writes dest 7/0x11, cycle 2 writes dest 9/0x22, wb_idle=1 in cycle 3.
- Fill and stall: DEPTH=4; exec + load on lane2 for 3 cycles → load_stall[2]=1 after the 3rd push. Exec stops → entries drain in push order over 3 cycles; load_stall drops once count=2.
- Overflow: exec + load on lane3 for 5 cycles with DEPTH=4 → load_overflow[3]=1 from cycle 5 and stays 1. Exactly 4 loads drain afterwards; the 5th is absent.
- Push-pop full: lane0 FIFO full, no exec, new load → head written, new load at tail, count=4, no overflow.
- Reset mid-drain: rst=1 with 2 queued loads → next cycle all vrf_write_enable=0, load_overflow=0, wb_idle=1. The queued loads are never written.
